// File: rtl/wide_add_pkg.sv
// Shared definitions for the chunk-serial wide adder: chunk width, sequencer
// states and the operand-width helper.
package wide_add_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calcWidth(input int nwords);
    return CHUNK_W * nwords;
  endfunction

endpackage

// File: rtl/carrybypass.sv
// 16-bit carry-bypass adder: four 4-bit ripple blocks, each skipped when every
// bit in the block propagates.
module carrybypass (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic        Cout,
  output logic [15:0] S
);

  logic [4:0]  w_blkCarry;
  logic [16:0] w_rip;
  logic [3:0]  w_prop;

  // w_rip holds the carry into each bit; a block's entry is the bypass carry
  always_comb begin
    w_blkCarry    = '0;
    w_rip         = '0;
    w_prop        = '0;
    w_blkCarry[0] = Cin;
    for (int b = 0; b < 4; b++) begin
      w_rip[4*b] = w_blkCarry[b];
      for (int i = 0; i < 4; i++) begin
        w_rip[4*b+i+1] = (A[4*b+i] & B[4*b+i]) | ((A[4*b+i] ^ B[4*b+i]) & w_rip[4*b+i]);
      end
      w_prop[b]       = &(A[4*b +: 4] ^ B[4*b +: 4]);
      w_blkCarry[b+1] = w_prop[b] ? w_blkCarry[b] : w_rip[4*b+4];
    end
  end

  assign S    = A ^ B ^ w_rip[15:0];
  assign Cout = w_blkCarry[4];

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract built from one 16-bit adder, fed one chunk per cycle LSB
// first, with the inter-chunk carry held in a register.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [calcWidth(NWORDS)-1:0] a_in,
  input  logic [calcWidth(NWORDS)-1:0] b_in,
  input  logic                         cin_in,
  input  logic                         sub_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [calcWidth(NWORDS)-1:0] sum_out,
  output logic                         cout_out,
  output logic                         ovf_out
);

  localparam int W     = calcWidth(NWORDS);
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e             r_state;
  state_e             w_nextState;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_aSh;
  logic [W-1:0]       r_bSh;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_outValid;
  logic [CHUNK_W-1:0] w_s;
  logic               w_cout;
  logic               w_accept;
  logic               w_lastChunk;
  logic [W-1:0]       w_sumShifted;

  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_lastChunk = (r_idx == LAST_IDX);

  carrybypass u_adder (
    .A    (r_aSh[CHUNK_W-1:0]),
    .B    (r_bSh[CHUNK_W-1:0]),
    .Cin  (r_carry),
    .Cout (w_cout),
    .S    (w_s)
  );

  // Each chunk enters the result from the top so the LSB chunk lands at bit 0
  if (NWORDS == 1) begin : gOneChunk
    assign w_sumShifted = w_s;
  end else begin : gManyChunks
    assign w_sumShifted = {w_s, r_sum[W-1:CHUNK_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_nextState = RUN;
      RUN:     if (w_lastChunk) w_nextState = DONE;
      DONE:    if (out_ready)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Subtraction is folded in at capture as A + ~B + 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_aSh   <= a_in;
            r_bSh   <= sub_in ? ~b_in : b_in;
            r_carry <= sub_in | cin_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sumShifted;
          r_aSh   <= r_aSh >> CHUNK_W;
          r_bSh   <= r_bSh >> CHUNK_W;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_lastChunk) begin
            r_cout     <= w_cout;
            r_ovf      <= (r_aSh[CHUNK_W-1] == r_bSh[CHUNK_W-1]) && (w_s[CHUNK_W-1] != r_aSh[CHUNK_W-1]);
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign sum_out   = r_sum;
  assign cout_out  = r_cout;
  assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed literal cases plus a randomized run against
// a whole-operand arithmetic model, and a single-chunk build checked alongside.
module tb_wide_add_seq;

  localparam int NW  = 4;
  localparam int W   = 16 * NW;
  localparam int NUM_RAND_OPS = 1500;
  localparam int NUM_ONE_OPS  = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, cin_in, sub_in;
  logic [W-1:0]  a_in, b_in, sum_out;
  logic          out_valid, out_ready, cout_out, ovf_out;

  logic          rst1;
  logic          in_valid1, in_ready1, cin_in1, sub_in1;
  logic [15:0]   a_in1, b_in1, sum_out1;
  logic          out_valid1, out_ready1, cout_out1, ovf_out1;

  int            assertCount = 0;
  int            failCount   = 0;
  logic          cmpEnable   = 1'b0;
  logic          dut1Done    = 1'b0;

  // model state: cycles left until the result appears, and the visible result
  int            mCount = 0;
  logic          mValid = 1'b0;
  logic [W-1:0]  mSum = '0, pSum;
  logic          mCout = 1'b0, mOvf = 1'b0, pCout, pOvf;

  always #5 clk = ~clk;

  wide_add_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in), .sub_in(sub_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .cout_out(cout_out), .ovf_out(ovf_out)
  );

  wide_add_seq #(.NWORDS(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in1), .b_in(b_in1), .cin_in(cin_in1), .sub_in(sub_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum_out(sum_out1),
    .cout_out(cout_out1), .ovf_out(ovf_out1)
  );

  // Reference result of an w-bit add/sub using plain wide arithmetic
  function automatic void refCalc(input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int w,
                                  output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] mask, full;
    logic [63:0] be;
    logic        c;
    mask = (65'd1 << w) - 65'd1;
    be   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = ({1'b0, a} & mask) + ({1'b0, be} & mask) + 65'(c);
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 4-chunk instance, advanced on each clock edge
  always @(posedge clk) begin
    if (rst) begin
      mCount = 0;
      mValid = 1'b0;
      mSum   = '0;
      mCout  = 1'b0;
      mOvf   = 1'b0;
    end else if (mValid && out_ready) begin
      mValid = 1'b0;
    end else if (mCount > 0) begin
      mCount--;
      if (mCount == 0) begin
        mValid = 1'b1;
        mSum   = pSum;
        mCout  = pCout;
        mOvf   = pOvf;
      end
    end else if (!mValid && in_valid) begin
      refCalc(a_in, b_in, cin_in, sub_in, W, pSum, pCout, pOvf);
      mCount = NW;
    end
  end

  always @(negedge clk) begin
    if (cmpEnable) begin
      checkOutput("cmp_in_ready", in_ready, (!mValid && mCount == 0 && !rst));
      checkOutput("cmp_out_valid", out_valid, mValid);
      checkOutput("cmp_cout", cout_out, mCout);
      checkOutput("cmp_ovf", ovf_out, mOvf);
      if (mCount == 0) checkOutput("cmp_sum", sum_out, mSum);
    end
  end

  // One complete operation on the 4-chunk instance with literal expectations
  task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input logic [W-1:0] expSum,
                               input logic expCout, input logic expOvf);
    int got, lat;
    @(posedge clk); #1;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub; in_valid = 1'b1; out_ready = 1'b0;
    got = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    checkOutput({tag, "_accept"}, got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      if (n > 0) @(negedge clk);
      else @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
    checkOutput({tag, "_latency"}, lat, NW);
    checkOutput({tag, "_sum"}, sum_out, expSum);
    checkOutput({tag, "_cout"}, cout_out, expCout);
    checkOutput({tag, "_ovf"}, ovf_out, expOvf);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic waitOutValid(input string tag, output int lat);
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
    checkOutput({tag, "_latency"}, lat, NW);
  endtask

  task automatic randWord(output logic [W-1:0] v);
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = {1'b1, {(W-1){1'b0}}};
      2:       v = '0;
      default: v = {$urandom, $urandom};
    endcase
  endtask

  initial begin
    #(10 * 80000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence for the 4-chunk instance
  initial begin
    int lat, ops, waitCyc;
    logic accPending;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin_in = 1'b0; sub_in = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 cmpEnable = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum_out, 0);
    checkOutput("reset_cout", cout_out, 0);
    checkOutput("reset_ovf", ovf_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);

    applyStimulus("add_chunk_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                  64'h0000_0000_0001_0000, 1'b0, 1'b0);
    applyStimulus("add_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                  64'h0, 1'b1, 1'b0);
    applyStimulus("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    applyStimulus("sub_neg", 64'h5, 64'h7, 1'b1, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // Backpressure: result must hold while a new operand waits upstream
    @(posedge clk); #1;
    a_in = 64'h1234_5678_9ABC_DEF0; b_in = 64'h0FED_CBA9_8765_4321;
    cin_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid("bp_first", lat);
    @(posedge clk); #1;
    a_in = 64'h10; b_in = 64'h20; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_sum", sum_out, 64'h2222_2222_2222_2211);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_in_ready", in_ready, 1);
    checkOutput("bp_idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitOutValid("bp_second", lat);
    checkOutput("bp_second_sum", sum_out, 64'h30);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while the third chunk is being added
    @(posedge clk); #1;
    a_in = 64'h1111; b_in = 64'h2222; cin_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_run_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_run_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rst_run_no_output", out_valid, 0);
    end
    applyStimulus("after_reset", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);

    // Randomized traffic with gaps on both handshakes
    ops = 0;
    accPending = 1'b0;
    for (int cyc = 0; cyc < 60000 && ops < NUM_RAND_OPS; cyc++) begin
      @(posedge clk); #1;
      if (accPending) begin
        in_valid = 1'b0;
        ops++;
      end
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        randWord(a_in);
        randWord(b_in);
        cin_in   = 1'($urandom_range(0, 1));
        sub_in   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accPending = in_valid && in_ready;
    end
    checkOutput("rand_ops_done", ops, NUM_RAND_OPS);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (NW + 4) @(posedge clk);

    waitCyc = 0;
    while (!dut1Done && waitCyc < 20000) begin
      @(posedge clk);
      waitCyc++;
    end
    checkOutput("one_chunk_done", dut1Done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Single-chunk instance: one RUN cycle per operation
  initial begin
    logic [63:0] s;
    logic        co, ov;
    int          got, lat;
    rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0; cin_in1 = 1'b0; sub_in1 = 1'b0;
    a_in1 = '0; b_in1 = '0;
    repeat (3) @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    checkOutput("one_reset_in_ready", in_ready1, 1);
    checkOutput("one_reset_sum", sum_out1, 0);
    for (int k = 0; k < NUM_ONE_OPS; k++) begin
      @(posedge clk); #1;
      a_in1 = 16'($urandom); b_in1 = 16'($urandom);
      if (k == 0) begin a_in1 = 16'h7FFF; b_in1 = 16'h0001; end
      cin_in1 = 1'($urandom_range(0, 1)); sub_in1 = 1'($urandom_range(0, 1));
      if (k == 0) begin cin_in1 = 1'b0; sub_in1 = 1'b0; end
      in_valid1 = 1'b1;
      got = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (in_ready1) begin got = 1; break; end
      end
      checkOutput("one_accept", got, 1);
      refCalc({48'b0, a_in1}, {48'b0, b_in1}, cin_in1, sub_in1, 16, s, co, ov);
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid1) begin lat = n; break; end
      end
      checkOutput("one_latency", lat, 1);
      if (k == 0) checkOutput("one_pin_sum", sum_out1, 16'h8000);
      if (k == 0) checkOutput("one_pin_ovf", ovf_out1, 1);
      checkOutput("one_sum", {48'b0, sum_out1}, s);
      checkOutput("one_cout", cout_out1, co);
      checkOutput("one_ovf", ovf_out1, ov);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
    end
    dut1Done = 1'b1;
  end

endmodule
